alu_access_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 52 +++++
 rtl/alu_access_arbiter_rr.sv | 23 ++
 rtl/alu_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_access_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the ALU access arbiter:
//   - word/opcode widths and the opcode encoding used by the ALU
//   - FSM state type
//   - latency_of(): opcode -> number of cycles the ALU inputs are held
//   - is_supported(): opcode is one the ALU implements
package alu_arb_pkg;

  localparam int ARB_WORD_SIZE    = 19;
  localparam int ARB_OPCODE_WIDTH = 5;

  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_NOT = 5'h00;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_AND = 5'h01;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_OR  = 5'h02;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_XOR = 5'h03;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_ADD = 5'h04;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_SUB = 5'h05;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_INC = 5'h06;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_DEC = 5'h07;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_MUL = 5'h08;
  localparam logic [ARB_OPCODE_WIDTH-1:0] OP_DIV = 5'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Cycles the ALU inputs must stay stable before the result is valid.
  // Unsupported opcodes still take one cycle so they flow through EXEC.
  function automatic int unsigned latency_of(input logic [ARB_OPCODE_WIDTH-1:0] opcode,
                                             input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
    int unsigned lat;
    lat = 1;
    if (opcode == OP_MUL) lat = mul_cycles;
    else if (opcode == OP_DIV) lat = div_cycles;
    return lat;
  endfunction

  function automatic logic is_supported(input logic [ARB_OPCODE_WIDTH-1:0] opcode);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
      OP_INC, OP_DEC, OP_MUL, OP_DIV: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_access_arbiter_rr.sv
// rr_arbiter_2
// Two-way round-robin grant, purely combinational.
//   req        : request vector (bit i = requester i)
//   last_grant : requester that was served most recently
//   grant      : one-hot grant; on a tie the requester other than
//                last_grant wins
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_access_arbiter.sv
// alu_access_arbiter
// Shares one combinational ALU between two requesters (0 = execute stage,
// 1 = address/loop-count helper). Accepts one request at a time with
// round-robin arbitration, holds the latched opcode/operands on the ALU
// for an opcode-dependent number of cycles, captures the result and
// returns it to the owner over a valid/ready response handshake.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   req_valid / req_ready     : per-requester request handshake
//   req{0,1}_opcode/operand_* : request payloads
//   resp_valid / resp_ready   : per-requester response handshake
//   resp_data / resp_err      : shared result and error flag
//   alu_opcode / alu_operand_*: registered drive into the ALU
//   alu_result                : combinational ALU output
//   busy                      : FSM is not idle
module alu_access_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WORD_SIZE    = ARB_WORD_SIZE,
  parameter int OPCODE_WIDTH = ARB_OPCODE_WIDTH,
  parameter int MUL_CYCLES   = 3,
  parameter int DIV_CYCLES   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [OPCODE_WIDTH-1:0] req0_opcode,
  input  logic [OPCODE_WIDTH-1:0] req1_opcode,
  input  logic [WORD_SIZE-1:0]    req0_operand_1,
  input  logic [WORD_SIZE-1:0]    req0_operand_2,
  input  logic [WORD_SIZE-1:0]    req1_operand_1,
  input  logic [WORD_SIZE-1:0]    req1_operand_2,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [WORD_SIZE-1:0]    resp_data,
  output logic                    resp_err,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [WORD_SIZE-1:0]    alu_operand_1,
  output logic [WORD_SIZE-1:0]    alu_operand_2,
  input  logic [WORD_SIZE-1:0]    alu_result,
  output logic                    busy
);

  localparam int MAX_L = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  // count holds at most MAX_L-1
  localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  state_t                  state_reg, state_next;
  logic                    owner_reg, owner_next;
  logic                    last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    err_pending_reg, err_pending_next;
  logic [OPCODE_WIDTH-1:0] opcode_reg, opcode_next;
  logic [WORD_SIZE-1:0]    op1_reg, op1_next;
  logic [WORD_SIZE-1:0]    op2_reg, op2_next;
  logic [WORD_SIZE-1:0]    resp_data_reg, resp_data_next;
  logic                    resp_err_reg, resp_err_next;

  logic [1:0]              grant;
  logic [OPCODE_WIDTH-1:0] sel_opcode;
  logic [WORD_SIZE-1:0]    sel_op1;
  logic [WORD_SIZE-1:0]    sel_op2;

  rr_arbiter_2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Payload of whichever requester currently holds the grant.
  assign sel_opcode = grant[1] ? req1_opcode    : req0_opcode;
  assign sel_op1    = grant[1] ? req1_operand_1 : req0_operand_1;
  assign sel_op2    = grant[1] ? req1_operand_2 : req0_operand_2;

  // Ready is combinational from req_valid in IDLE. Gating with reset keeps
  // it low while reset is held, since the FSM sits in IDLE then.
  assign req_ready     = (state_reg == IDLE && !reset) ? grant : 2'b00;
  assign resp_valid    = (state_reg == RESP) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data     = resp_data_reg;
  assign resp_err      = resp_err_reg;
  assign alu_opcode    = opcode_reg;
  assign alu_operand_1 = op1_reg;
  assign alu_operand_2 = op2_reg;
  assign busy          = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      count_reg       <= '0;
      err_pending_reg <= 1'b0;
      opcode_reg      <= '0;
      op1_reg         <= '0;
      op2_reg         <= '0;
      resp_data_reg   <= '0;
      resp_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_grant_reg  <= last_grant_next;
      count_reg       <= count_next;
      err_pending_reg <= err_pending_next;
      opcode_reg      <= opcode_next;
      op1_reg         <= op1_next;
      op2_reg         <= op2_next;
      resp_data_reg   <= resp_data_next;
      resp_err_reg    <= resp_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_grant_next  = last_grant_reg;
    count_next       = count_reg;
    err_pending_next = err_pending_reg;
    opcode_next      = opcode_reg;
    op1_next         = op1_reg;
    op2_next         = op2_reg;
    resp_data_next   = resp_data_reg;
    resp_err_next    = resp_err_reg;

    case (state_reg)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_next = grant[1];
          if (sel_opcode == OP_DIV && sel_op2 == '0) begin
            // Divide-by-zero short-circuits: the ALU registers keep their
            // previous values so the ALU never sees the illegal divide.
            resp_data_next = '1;
            resp_err_next  = 1'b1;
            state_next     = RESP;
          end else begin
            opcode_next      = sel_opcode;
            op1_next         = sel_op1;
            op2_next         = sel_op2;
            count_next       = CNT_W'(latency_of(sel_opcode, MUL_CYCLES, DIV_CYCLES) - 1);
            err_pending_next = !is_supported(sel_opcode);
            state_next       = EXEC;
          end
        end
      end
      EXEC: begin
        if (count_reg == '0) begin
          resp_data_next = alu_result;
          resp_err_next  = err_pending_reg;
          state_next     = RESP;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      RESP: begin
        // Only the owner's resp_ready completes the response.
        if (resp_ready[owner_reg]) begin
          last_grant_next = owner_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Testbench for alu_access_arbiter: directed steps followed by randomized
// single/dual requests, checked against a transaction-level model of the
// arbitration order, latency and result of each operation.
module tb_alu_access_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [4:0]   req0_opcode, req1_opcode;
  logic [W-1:0] req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_operand_1, alu_operand_2;
  logic [W-1:0] alu_result;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  // Behavioural ALU: result of an operation in plain arithmetic, modulo 2^W.
  function automatic logic [W-1:0] calc(input logic [4:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_INC: r = a + 19'd1;
      OP_DEC: r = a - 19'd1;
      OP_MUL: r = a * b;
      OP_DIV: r = (b == '0) ? '1 : a / b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_result = calc(alu_opcode, alu_operand_1, alu_operand_2);

  alu_access_arbiter #(
    .WORD_SIZE(19), .OPCODE_WIDTH(5), .MUL_CYCLES(3), .DIV_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2),
    .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: drive request mask v, wait for and check the response,
  // hold resp_ready low for 'hold' cycles (non-owner ready asserted), then
  // accept it.
  task automatic do_op(input logic [1:0] v,
                       input logic [4:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [4:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int hold);
    int w, lat, k;
    logic [4:0]   op;
    logic [W-1:0] a, b, ed, d0;
    logic         ee, sup;
    logic [1:0]   oh;
    w   = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : (1 - model_last);
    oh  = (w == 1) ? 2'b10 : 2'b01;
    op  = (w == 1) ? o1 : o0;
    a   = (w == 1) ? a1 : a0;
    b   = (w == 1) ? b1 : b0;
    sup = (op <= OP_DIV);
    ed  = calc(op, a, b);
    ee  = !sup || (op == OP_DIV && b == '0);
    lat = (op == OP_MUL) ? 3 : (op == OP_DIV) ? ((b == '0) ? 0 : 10) : 1;

    @(negedge clk);
    req_valid = v;
    req0_opcode = o0; req0_operand_1 = a0; req0_operand_2 = b0;
    req1_opcode = o1; req1_operand_1 = a1; req1_operand_2 = b1;
    #1;
    chk("req_ready_grant", {30'd0, req_ready}, {30'd0, oh});
    chk("busy_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    k = 1;
    while (resp_valid == 2'b00 && k <= 40) begin
      chk("busy_exec", {31'd0, busy}, 32'd1);
      chk("alu_opcode_hold", {27'd0, alu_opcode}, {27'd0, op});
      chk("alu_op1_hold", {13'd0, alu_operand_1}, {13'd0, a});
      chk("alu_op2_hold", {13'd0, alu_operand_2}, {13'd0, b});
      @(negedge clk);
      k++;
    end
    chk("resp_latency", k, lat + 1);
    chk("resp_valid_owner", {30'd0, resp_valid}, {30'd0, oh});
    if (sup) chk("resp_data", {13'd0, resp_data}, {13'd0, ed});
    chk("resp_err", {31'd0, resp_err}, {31'd0, ee});
    d0 = resp_data;
    req_valid  = 2'b11;
    resp_ready = ~oh;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_resp_valid", {30'd0, resp_valid}, {30'd0, oh});
      chk("hold_resp_data", {13'd0, resp_data}, {13'd0, d0});
      chk("hold_req_ready", {30'd0, req_ready}, 32'd0);
    end
    req_valid  = 2'b00;
    resp_ready = oh;
    @(negedge clk);
    resp_ready = 2'b00;
    chk("resp_drop", {30'd0, resp_valid}, 32'd0);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    model_last = w;
    $display("txn v=%b owner=%0d op=%0h a=%0h b=%0h data=%0h err=%0d lat=%0d", v, w, op, a, b, d0, ee, lat);
  endtask

  initial begin
    int n, w, r;
    logic [1:0] oh, v;
    logic [4:0] o0, o1;
    logic [W-1:0] a0, b0, a1, b1;

    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00;
    req0_opcode = '0; req1_opcode = '0;
    req0_operand_1 = '0; req0_operand_2 = '0; req1_operand_1 = '0; req1_operand_2 = '0;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_data", {13'd0, resp_data}, 32'd0);
    chk("rst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_last = 1;

    // Both requesters continuously valid with INC 0x10: grants alternate.
    req0_opcode = OP_INC; req1_opcode = OP_INC;
    req0_operand_1 = 19'h10; req1_operand_1 = 19'h10;
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w  = 1 - model_last;
      oh = (w == 1) ? 2'b10 : 2'b01;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 30) begin @(negedge clk); #1; n++; end
      chk("alt_grant", {30'd0, req_ready}, {30'd0, oh});
      @(negedge clk);
      n = 0;
      while (resp_valid == 2'b00 && n < 30) begin @(negedge clk); n++; end
      chk("alt_resp_owner", {30'd0, resp_valid}, {30'd0, oh});
      chk("alt_resp_data", {13'd0, resp_data}, 32'h11);
      $display("txn alt grant=%0d data=%0h", w, resp_data);
      model_last = w;
      @(negedge clk);
    end
    req_valid = 2'b00; resp_ready = 2'b00;

    do_op(2'b01, OP_ADD, 19'd5, 19'd7, 5'd0, '0, '0, 0);
    do_op(2'b01, OP_MUL, 19'd3, 19'd4, 5'd0, '0, '0, 5);
    do_op(2'b01, OP_DIV, 19'd100, 19'd0, 5'd0, '0, '0, 1);
    do_op(2'b10, 5'd0, '0, '0, OP_DIV, 19'd100, 19'd7, 0);
    do_op(2'b01, 5'h1F, 19'd9, 19'd9, 5'd0, '0, '0, 0);
    do_op(2'b10, 5'd0, '0, '0, OP_SUB, 19'd3, 19'd5, 0);

    for (int i = 0; i < 25; i++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = 19'($urandom); b0 = 19'($urandom); a1 = 19'($urandom); b1 = 19'($urandom);
      r  = $urandom_range(0, 11);
      o0 = (r == 10) ? 5'h1F : (r == 11) ? OP_DIV : 5'(r);
      if (r == 11) b0 = '0;
      r  = $urandom_range(0, 11);
      o1 = (r == 10) ? 5'h13 : (r == 11) ? OP_DIV : 5'(r);
      if (r == 11) b1 = '0;
      do_op(v, o0, a0, b0, o1, a1, b1, $urandom_range(0, 2));
    end

    // Reset in the middle of a DIV: everything clears at once, no response.
    @(negedge clk);
    req_valid = 2'b01; req0_opcode = OP_DIV; req0_operand_1 = 19'd100; req0_operand_2 = 19'd7;
    @(negedge clk);
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("arst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_resp_data", {13'd0, resp_data}, 32'd0);
    chk("arst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("arst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
    chk("arst_alu_op1", {13'd0, alu_operand_1}, 32'd0);
    chk("arst_alu_op2", {13'd0, alu_operand_2}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || busy) n++;
    end
    chk("arst_no_resp", n, 0);
    do_op(2'b11, OP_XOR, 19'h5A5A5, 19'h0F0F0, OP_ADD, 19'd1, 19'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
